gps_uart_tx: RTL and testbench
==============================

// Module: gps_uart_tx
// PURPOSE
//  Fabric UART transmitter that drives gps_txd to the GPS receiver for configuration
//  and command sentences. Bytes are written from the register block into a small
//  FIFO and sent as 8N1 frames. Sending can optionally be held until the next tsc_1pps,
//  so that a queued burst goes out aligned to the local second.
// PARAMETERS
//  FIFO_AW   4   FIFO address width; depth = 2**FIFO_AW bytes (default 16)
//  MIN_DIV   2   smallest legal bit period in clk cycles; smaller baud_div is clamped to this
// PORTS
//  clk        in   1       system clock (100 MHz OCXO domain)
//  rst        in   1       synchronous reset, active-high
//  ena        in   1       transmitter enable
//  baud_div   in   16      bit period in clk cycles (e.g. 10417 = 9600 baud)
//  pps_align  in   1       1 = hold queued bytes until tsc_1pps
//  tsc_1pps   in   1       single-cycle pulse at the local second
//  wr         in   1       push wr_data into the FIFO
//  wr_data    in   8       byte to send
//  ovf_clr    in   1       clear the sticky overflow flag
//  full       out  1       FIFO full
//  empty      out  1       FIFO empty
//  level      out  FIFO_AW+1  FIFO occupancy
//  ovf        out  1       sticky flag: a write was dropped
//  busy       out  1       a frame is in progress (states START, DATA, STOP)
//  txd        out  1       serial data; idles high
//  txd_t      out  1       tristate control: 0 = drive txd, 1 = high-Z; equals ~ena
// BEHAVIOUR
//  Reset: txd=1, txd_t=1, busy=0, ovf=0, FIFO emptied (empty=1, full=0, level=0), state IDLE.
//   Reset mid-frame aborts the frame; txd is 1 on the next cycle.
//  FIFO:
//   - A write is accepted when wr && (!full || pop in the same cycle).
//   - If wr && full && no pop, the byte is dropped and ovf is set.
//   - If ovf_clr and a dropped write happen in the same cycle, ovf is set.
//   - level updates one cycle after push/pop; a simultaneous push and pop leaves level unchanged.
//  Frame format: start bit 0, 8 data bits LSB first, 1 stop bit 1.
//   - Each bit lasts D = max(baud_div, MIN_DIV) cycles. D is captured at frame start,
//     so changing baud_div mid-frame has no effect on the current frame.
//  State machine:
//   - IDLE     -> WAIT_PPS if ena && !empty && pps_align; -> START if ena && !empty && !pps_align.
//   - WAIT_PPS -> START on tsc_1pps (when !empty); -> IDLE if !ena.
//   - START    pops the FIFO head into the shift register and drives 0 for D cycles -> DATA.
//   - DATA     8 bits of D cycles each -> STOP.
//   - STOP     drives 1 for D cycles, then:
//       -> START (back-to-back, no idle gap) if ena && !empty, which also continues an aligned burst;
//       -> IDLE otherwise.
//  Latency: a write at cycle N into an empty FIFO, in IDLE with ena=1 and pps_align=0,
//   gives the first start-bit cycle on txd at N+2.
//  pps_align: one tsc_1pps releases the whole queue, including bytes written during the burst.
//   It re-arms only after the FIFO empties and the state returns to IDLE.
//   A tsc_1pps that arrives while busy is ignored.
//  ena falling mid-frame: the current frame completes, then the state goes to IDLE.
//   The FIFO keeps its contents. txd_t follows ena immediately.
// STRUCTURE
//  types_pkg additions:
//   - typedef enum uart_tx_state_t {IDLE, WAIT_PPS, START, DATA, STOP}
//   - localparam UART_DATA_BITS = 8
//  Sub-module: sync_fifo (width 8, depth 2**FIFO_AW, synchronous, active-high rst,
//   full/empty/level outputs). It is shared with a later receive path.
//  The top level holds the FSM, the bit counter, the baud counter and the shift register.
// TESTING
//  1. baud_div=4, write 0x55 -> txd: 0 x4 clk, then 1,0,1,0,1,0,1,0 x4 clk each, then 1 x4 clk;
//     busy high for 40 clk; start bit begins 2 clk after wr.
//  2. ena=0, write 17 bytes -> level=16, full=1, ovf=1, nothing sent.
//     Then ovf_clr -> ovf=0; ena=1 -> 16 back-to-back frames, then empty=1.
//  3. pps_align=1, baud_div=4, write 0x01,0x02,0x03 -> txd stays 1 until tsc_1pps;
//     then 120 contiguous clk of frames; a second tsc_1pps during the burst has no effect.
//  4. Assert rst at bit 3 of a frame -> txd=1, level=0, busy=0 on the next cycle;
//     no frame resumes after rst is released.
//  5. Drop ena in the DATA state -> the frame ends with a correct stop bit, txd_t=1 at once,
//     the remaining bytes stay queued.
//  6. baud_div=0 -> bit period 2 clk (clamped); baud_div changed mid-frame -> the current
//     frame keeps the old period and the next frame uses the new one.

Source files
------------

// File: rtl/gps_uart_tx_pkg.sv
// Shared types for the GPS UART transmit path: FSM states, frame constants
// and the bit-period clamp.
package gps_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PPS,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic logic [15:0] clamp_div(input logic [15:0] div,
                                              input logic [15:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/gps_uart_tx_if.sv
// Register-block side of the GPS UART transmitter: byte push port and FIFO status.
interface gps_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    // wr is a one-cycle push strobe with no back-pressure: the byte is taken when
    // !full or when a byte leaves the FIFO in the same cycle; otherwise it is lost
    // and ovf latches until ovf_clr.
    logic               wr;
    logic [7:0]         wr_data;
    logic               ovf_clr;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   level;
    logic               ovf;

    modport master (
        output wr, wr_data, ovf_clr,
        input  full, empty, level, ovf
    );

    modport slave (
        input  wr, wr_data, ovf_clr,
        output full, empty, level, ovf
    );

endinterface

// File: rtl/gps_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is read combinationally.
// Also used by the receive path.
module gps_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == DEPTH);
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/gps_uart_tx.sv
// 8N1 transmitter toward the GPS receiver: FIFO-fed, optionally released by tsc_1pps
// so a queued burst starts on the local second.
module gps_uart_tx
    import gps_uart_tx_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int MIN_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [15:0]     baud_div,
    input  logic            pps_align,
    input  logic            tsc_1pps,
    gps_uart_tx_if.slave    bus,
    output logic            busy,
    output logic            txd,
    output logic            txd_t,
    output uart_tx_state_t  dbg_state
);

    localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    div_q, div_d;
    logic [15:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           ovf_q, ovf_d;
    logic           pop, start_frame, drop;
    logic [7:0]     head;
    logic [15:0]    div_now;

    gps_uart_tx_sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr),
        .push_data_i (bus.wr_data),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (bus.full),
        .empty_o     (bus.empty),
        .level_o     (bus.level)
    );

    assign div_now = clamp_div(baud_div, MIN_DIV_W);

    // A dropped write wins over a simultaneous clear.
    assign drop  = bus.wr && bus.full && !pop;
    assign ovf_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (ena && !bus.empty) begin
                    if (pps_align) state_d = WAIT_PPS;
                    else           start_frame = 1'b1;
                end
            end
            WAIT_PPS: begin
                if (!ena)                         state_d = IDLE;
                else if (tsc_1pps && !bus.empty)  start_frame = 1'b1;
            end
            START: begin
                if (baud_cnt_q == '0) begin
                    state_d    = DATA;
                    baud_cnt_d = div_q - 16'd1;
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {1'b0, shift_q[7:1]};
                    baud_cnt_d = div_q - 16'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                    else                       bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            STOP: begin
                // Chaining straight into the next frame also carries an aligned burst on.
                if (baud_cnt_q == '0) begin
                    if (ena && !bus.empty) start_frame = 1'b1;
                    else                   state_d = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit period is latched here so baud_div changes only affect later frames.
        if (start_frame) begin
            state_d    = START;
            pop        = 1'b1;
            shift_d    = head;
            div_d      = div_now;
            baud_cnt_d = div_now - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= MIN_DIV_W;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    assign busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign txd_t     = ~ena;
    assign bus.ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gps_uart_tx.sv
// Bench for gps_uart_tx: directed scenarios plus random traffic, with a serial
// monitor that decodes txd and checks every frame against an expected byte queue.
module tb_gps_uart_tx;
    import gps_uart_tx_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ena = 1'b0;
    logic           pps_align = 1'b0;
    logic           tsc_1pps = 1'b0;
    logic [15:0]    baud_div = 16'd4;
    logic           busy, txd, txd_t;
    uart_tx_state_t dbg_state;

    gps_uart_tx_if #(.FIFO_AW(AW)) bus ();

    gps_uart_tx #(.FIFO_AW(AW), .MIN_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .baud_div  (baud_div),
        .pps_align (pps_align),
        .tsc_1pps  (tsc_1pps),
        .bus       (bus),
        .busy      (busy),
        .txd       (txd),
        .txd_t     (txd_t),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          model_cnt = 0;
    logic        exp_ovf = 1'b0;
    int          frames_seen = 0;
    logic [15:0] bd_at_edge = 16'd4;

    // baud_div as the DUT saw it on the most recent edge
    always @(posedge clk) bd_at_edge = baud_div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic clr);
        @(posedge clk);
        #1;
        bus.wr      = 1'b1;
        bus.wr_data = b;
        bus.ovf_clr = clr;
        if (model_cnt < DEPTH) begin
            exp_q.push_back(b);
            model_cnt++;
            if (clr) exp_ovf = 1'b0;
        end else begin
            exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.wr      = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!(bus.empty && !busy) && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk(name, 32'(w < budget), 1);
    endtask

    // waits for a frame to start, then counts contiguous busy cycles
    task automatic busy_run(input int budget, output int cnt);
        int w;
        w = 0;
        cnt = 0;
        @(negedge clk);
        while (!busy && w < budget) begin
            @(negedge clk);
            w++;
        end
        while (busy && cnt < budget) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // ---------------- monitor: decode txd, compare with exp_q ----------------
    initial begin : monitor
        int         d, bidx;
        logic [7:0] exp_b, got;
        logic       expb;
        bit         shape_ok, aborted;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                d = (bd_at_edge < 16'd2) ? 2 : int'(bd_at_edge);
                model_cnt--;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    exp_b = 8'h00;
                end else begin
                    exp_b = exp_q.pop_front();
                end
                shape_ok = (busy === 1'b1);
                got      = 8'h00;
                aborted  = 1'b0;
                for (int i = 1; i < 10 * d; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    bidx = i / d;
                    if (bidx == 0)      expb = 1'b0;
                    else if (bidx == 9) expb = 1'b1;
                    else                expb = exp_b[bidx-1];
                    if (txd !== expb || busy !== 1'b1) shape_ok = 1'b0;
                    if (bidx >= 1 && bidx <= 8 && (i % d) == d / 2) got[bidx-1] = txd;
                end
                if (!aborted) begin
                    chk("frame_data", 32'(got), 32'(exp_b));
                    chk("frame_shape", 32'(shape_ok), 1);
                    frames_seen++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int cnt, fbase;
        bit held;
        logic [7:0] b;

        bus.wr      = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", 32'(txd), 1);
        chk("rst_txd_t", 32'(txd_t), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single 0x55 at D=4, latency and frame length
        ena = 1'b1;
        baud_div = 16'd4;
        tick(2);
        chk("t1_txd_t_on", 32'(txd_t), 0);
        bus.wr = 1'b1;
        bus.wr_data = 8'h55;
        exp_q.push_back(8'h55);
        model_cnt++;
        @(posedge clk);
        #1 bus.wr = 1'b0;
        @(negedge clk);
        chk("t1_lat_n1_txd", 32'(txd), 1);
        @(negedge clk);
        chk("t1_lat_n2_start", 32'(txd), 0);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("t1_busy_len", 32'(cnt), 40);
        wait_idle(50, "t1_idle");

        // 2: fill with ena=0, overflow, clear, drain
        ena = 1'b0;
        baud_div = 16'd2;
        fbase = frames_seen;
        for (int i = 0; i < 17; i++) write_byte(8'($urandom), 1'b0);
        @(negedge clk);
        chk("t2_level", 32'(bus.level), DEPTH);
        chk("t2_full", 32'(bus.full), 1);
        chk("t2_ovf", 32'(bus.ovf), 32'(exp_ovf));
        chk("t2_not_sent", 32'(busy), 0);
        chk("t2_txd_t_off", 32'(txd_t), 1);
        write_byte(8'($urandom), 1'b1);
        @(negedge clk);
        chk("t2_ovf_clr_vs_drop", 32'(bus.ovf), 1);
        @(posedge clk);
        #1 bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1 bus.ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("t2_ovf_cleared", 32'(bus.ovf), 32'(exp_ovf));
        @(posedge clk);
        #1 ena = 1'b1;
        wait_idle(16 * 20 + 50, "t2_drain");
        chk("t2_frames", 32'(frames_seen - fbase), 16);
        chk("t2_empty", 32'(bus.empty), 1);

        // 3: pps-aligned burst of three bytes
        pps_align = 1'b1;
        baud_div = 16'd4;
        write_byte(8'h01, 1'b0);
        write_byte(8'h02, 1'b0);
        write_byte(8'h03, 1'b0);
        held = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) held = 1'b0;
        end
        chk("t3_held", 32'(held), 1);
        chk("t3_wait_state", 32'(dbg_state), 32'(WAIT_PPS));
        @(posedge clk);
        #1 tsc_1pps = 1'b1;
        @(posedge clk);
        #1 tsc_1pps = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 400) begin
            cnt++;
            tsc_1pps = (cnt == 60);
            @(negedge clk);
        end
        tsc_1pps = 1'b0;
        chk("t3_burst_len", 32'(cnt), 120);
        tick(20);
        chk("t3_no_retrigger", 32'(busy), 0);
        write_byte(8'h04, 1'b0);
        tick(20);
        chk("t3_rearmed_hold", 32'(busy), 0);
        @(posedge clk);
        #1 tsc_1pps = 1'b1;
        @(posedge clk);
        #1 tsc_1pps = 1'b0;
        wait_idle(100, "t3_rearm_send");
        pps_align = 1'b0;

        // 4: reset mid-frame
        write_byte(8'($urandom), 1'b0);
        write_byte(8'($urandom), 1'b0);
        tick(14);
        chk("t4_in_data", 32'(dbg_state), 32'(DATA));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_txd", 32'(txd), 1);
        chk("t4_level", 32'(bus.level), 0);
        chk("t4_busy", 32'(busy), 0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) held = 1'b0;
        end
        chk("t4_no_resume", 32'(held), 1);

        // 5: drop ena during DATA
        write_byte(8'($urandom), 1'b0);
        write_byte(8'($urandom), 1'b0);
        write_byte(8'($urandom), 1'b0);
        tick(8);
        chk("t5_in_data", 32'(dbg_state), 32'(DATA));
        ena = 1'b0;
        #1;
        chk("t5_txd_t_now", 32'(txd_t), 1);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        tick(20);
        chk("t5_stopped", 32'(busy), 0);
        chk("t5_state", 32'(dbg_state), 32'(IDLE));
        chk("t5_level_kept", 32'(bus.level), 2);
        ena = 1'b1;
        wait_idle(200, "t5_resume");

        // 6: clamped period, then mid-frame baud change
        ena = 1'b0;
        baud_div = 16'd0;
        write_byte(8'($urandom), 1'b0);
        @(posedge clk);
        #1 ena = 1'b1;
        busy_run(100, cnt);
        chk("t6_clamped_len", 32'(cnt), 20);
        ena = 1'b0;
        baud_div = 16'd6;
        write_byte(8'($urandom), 1'b0);
        write_byte(8'($urandom), 1'b0);
        @(posedge clk);
        #1 ena = 1'b1;
        cnt = 0;
        held = 1'b0;
        @(negedge clk);
        while (!busy && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            if (cnt == 15) baud_div = 16'd3;
            @(negedge clk);
        end
        chk("t6_mixed_len", 32'(cnt), 90);

        // random traffic
        for (int i = 0; i < 14; i++) begin
            baud_div = 16'($urandom_range(0, 5));
            b = 8'($urandom);
            write_byte(b, 1'b0);
            tick($urandom_range(0, 30));
        end
        wait_idle(2000, "rand_drain");

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_ovf", 32'(bus.ovf), 32'(exp_ovf));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
